udp_rx_payload_extract: RTL and testbench



---
 rtl/udp_rx_payload_extract.sv | 159 +++++++++++++++
 tb/tb_udp_rx_payload_extract.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_payload_extract.sv
// rtl/udp_rx_payload_extract.sv - UDP receive parser packing payload into a word buffer and bursting it out
//
// Ports:
//   clk, nRST  - clock (rising edge) and asynchronous active-low reset
//   rx_dv      - frame valid, high for the whole frame (preamble/SFD/FCS removed)
//   rx_data    - frame byte, sampled while rx_dv=1
//   data_out   - big-endian payload word, 0 whenever en_out=0
//   en_out     - high for ceil(L/4) consecutive cycles per accepted frame
//   frame_len  - payload byte count of the current/last burst
//   pkt_ok     - pulse in the first cycle of a burst
//   pkt_drop   - pulse when a frame is rejected or truncated
module udp_rx_payload_extract #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A35010203,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT = 16'h1F90,
  parameter int          BUF_AW     = 9
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic [31:0] data_out,
  output logic        en_out,
  output logic [10:0] frame_len,
  output logic        pkt_ok,
  output logic        pkt_drop
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, TAIL, DROP, BURST} state_t;

  localparam int              PW      = BUF_AW + 3;
  localparam logic [15:0]     MAX_UDP = 16'(4 * (2 ** BUF_AW) + 8);
  localparam logic [PW-1:0]   PONE    = PW'(1);

  state_t              state, state_n;
  logic [10:0]         cnt, idx;
  logic                mac_loc, mac_bc, mac_loc_n, mac_bc_n;
  logic [7:0]          mac_exp, ip_exp, udp_hi;
  logic [1:0]          ip_off;
  logic [15:0]         udp_len;
  logic                hdr_fail, drop_pulse;
  logic [10:0]         plen;
  logic [PW-1:0]       pay_cnt, pay_end;
  logic                pay_last, wr_en;
  logic [31:0]         acc, acc_n;
  logic [BUF_AW-1:0]   last_word, rd_idx;
  logic [31:0]         mem [2**BUF_AW];
  logic [31:0]         rd_data;
  logic                rd_v, rd_first;

  // Header checks. In IDLE the incoming byte is byte 0, so idx is forced to 0.
  always_comb begin
    idx       = (state == IDLE) ? 11'd0 : cnt;
    mac_exp   = 8'(LOCAL_MAC >> {3'd5 - idx[2:0], 3'b000});
    ip_off    = idx[1:0] - 2'd2;
    ip_exp    = 8'(LOCAL_IP >> {2'd3 - ip_off, 3'b000});
    udp_len   = {udp_hi, rx_data};
    // Unicast and broadcast matches are tracked separately so mixed bytes fail.
    mac_loc_n = ((idx == 11'd0) | mac_loc) & (rx_data == mac_exp);
    mac_bc_n  = ((idx == 11'd0) | mac_bc) & (rx_data == 8'hFF);
    hdr_fail  = 1'b0;
    case (idx)
      11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5: hdr_fail = !(mac_loc_n | mac_bc_n);
      11'd12: hdr_fail = (rx_data != 8'h08);
      11'd13: hdr_fail = (rx_data != 8'h00);
      11'd14: hdr_fail = (rx_data != 8'h45);
      11'd23: hdr_fail = (rx_data != 8'h11);
      11'd30, 11'd31, 11'd32, 11'd33: hdr_fail = (rx_data != ip_exp);
      11'd36: hdr_fail = (rx_data != LOCAL_PORT[15:8]);
      11'd37: hdr_fail = (rx_data != LOCAL_PORT[7:0]);
      11'd39: hdr_fail = (udp_len < 16'd9) || (udp_len > MAX_UDP);
      default: hdr_fail = 1'b0;
    endcase
  end

  // Payload byte i lands in lane 3-(i mod 4); a new word starts from zero.
  always_comb begin
    pay_last = (pay_cnt == pay_end);
    acc_n    = ((pay_cnt[1:0] == 2'd0) ? 32'd0 : acc) |
               ({24'd0, rx_data} << {~pay_cnt[1:0], 3'b000});
    wr_en    = (state == PAYLOAD) && rx_dv && ((pay_cnt[1:0] == 2'd3) || pay_last);
  end

  always_comb begin
    state_n    = state;
    drop_pulse = 1'b0;
    case (state)
      IDLE: if (rx_dv) begin
        if (hdr_fail) begin state_n = DROP; drop_pulse = 1'b1; end
        else          state_n = HDR;
      end
      HDR: begin
        if (!rx_dv)             begin state_n = IDLE; drop_pulse = 1'b1; end
        else if (hdr_fail)      begin state_n = DROP; drop_pulse = 1'b1; end
        else if (idx == 11'd41) state_n = PAYLOAD;
      end
      PAYLOAD: begin
        if (!rx_dv)        begin state_n = IDLE; drop_pulse = 1'b1; end
        else if (pay_last) state_n = TAIL;
      end
      TAIL: if (!rx_dv) state_n = BURST;
      DROP: if (!rx_dv) state_n = IDLE;
      // A frame that overlaps the burst is swallowed silently.
      BURST: if (rd_idx == last_word) state_n = rx_dv ? DROP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      mac_loc   <= 1'b0;
      mac_bc    <= 1'b0;
      udp_hi    <= '0;
      plen      <= '0;
      pay_end   <= '0;
      last_word <= '0;
      pay_cnt   <= '0;
      acc       <= '0;
      rd_idx    <= '0;
      rd_v      <= 1'b0;
      rd_first  <= 1'b0;
      data_out  <= '0;
      en_out    <= 1'b0;
      frame_len <= '0;
      pkt_ok    <= 1'b0;
      pkt_drop  <= 1'b0;
    end else begin
      state    <= state_n;
      pkt_drop <= drop_pulse;
      cnt      <= (state_n == HDR) ? idx + 11'd1 : 11'd0;
      mac_loc  <= mac_loc_n;
      mac_bc   <= mac_bc_n;
      if (state == HDR && idx == 11'd38) udp_hi <= rx_data;
      if (state == HDR && idx == 11'd39) begin
        plen      <= 11'(udp_len - 16'd8);
        pay_end   <= PW'(udp_len - 16'd9);
        last_word <= BUF_AW'((udp_len - 16'd9) >> 2);
      end
      pay_cnt <= (state == PAYLOAD && rx_dv) ? pay_cnt + PONE : '0;
      if (state == PAYLOAD && rx_dv) acc <= acc_n;
      // Two-stage read: address issue, registered RAM read, then output register.
      rd_idx   <= (state == BURST) ? rd_idx + BUF_AW'(1) : '0;
      rd_v     <= (state == BURST);
      rd_first <= (state == BURST) && (rd_idx == '0);
      en_out   <= rd_v;
      data_out <= rd_v ? rd_data : 32'd0;
      pkt_ok   <= rd_first;
      if (rd_first) frame_len <= plen;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[pay_cnt[BUF_AW+1:2]] <= acc_n;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: tb/tb_udp_rx_payload_extract.sv
// tb/tb_udp_rx_payload_extract.sv - self-checking bench for udp_rx_payload_extract
module tb_udp_rx_payload_extract;

  localparam logic [47:0] LMAC  = 48'h000A35010203;
  localparam logic [31:0] LIP   = 32'hC0A80002;
  localparam logic [15:0] LPORT = 16'h1F90;

  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] data_out;
  logic        en_out;
  logic [10:0] frame_len;
  logic        pkt_ok;
  logic        pkt_drop;

  udp_rx_payload_extract dut (
    .clk(clk), .nRST(nRST), .rx_dv(rx_dv), .rx_data(rx_data),
    .data_out(data_out), .en_out(en_out), .frame_len(frame_len),
    .pkt_ok(pkt_ok), .pkt_drop(pkt_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Output monitor: everything observed at the falling edge.
  logic [31:0] got[$];
  int          rise_q[$];
  int          run_q[$];
  int          drop_q[$];
  logic [10:0] oklen_q[$];
  int          n_ok = 0, n_drop = 0, zero_err = 0, run = 0;
  logic        prev_en = 1'b0;

  always @(negedge clk) begin
    if (en_out) begin
      got.push_back(data_out);
      if (!prev_en) rise_q.push_back(cyc);
      run = run + 1;
    end else begin
      if (prev_en) run_q.push_back(run);
      run = 0;
      if (data_out !== 32'd0) zero_err = zero_err + 1;
    end
    if (pkt_ok) begin n_ok = n_ok + 1; oklen_q.push_back(frame_len); end
    if (pkt_drop) begin n_drop = n_drop + 1; drop_q.push_back(cyc); end
    prev_en = en_out;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame builder: Ethernet/IPv4/UDP header, npay payload bytes, padded to pad_to bytes.
  function automatic void build(input logic [47:0] mac, input logic [15:0] port,
                                input int ulen, input int npay, input int pad_to,
                                output logic [7:0] f[$]);
    logic [7:0] h[42];
    f = {};
    for (int i = 0; i < 42; i++) h[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) h[i] = mac[47-8*i -: 8];
    h[12] = 8'h08; h[13] = 8'h00; h[14] = 8'h45; h[23] = 8'h11;
    for (int i = 0; i < 4; i++) h[30+i] = LIP[31-8*i -: 8];
    h[36] = port[15:8]; h[37] = port[7:0];
    h[38] = 8'(ulen >> 8); h[39] = 8'(ulen);
    for (int i = 0; i < 42; i++) f.push_back(h[i]);
    for (int i = 0; i < npay; i++) f.push_back(8'($urandom));
    while (f.size() < pad_to) f.push_back(8'($urandom));
  endfunction

  // Reference model: decides acceptance from the header rules and packs the payload.
  function automatic void model(input logic [7:0] f[$], output bit acc, output int plen,
                                output logic [31:0] w[$]);
    logic [47:0] mac;
    logic [31:0] ip;
    int ul;
    acc = 1'b0; plen = 0; w = {};
    if (f.size() < 42) return;
    mac = {f[0], f[1], f[2], f[3], f[4], f[5]};
    ip  = {f[30], f[31], f[32], f[33]};
    ul  = {f[38], f[39]};
    if (mac != LMAC && mac != 48'hFFFFFFFFFFFF) return;
    if ({f[12], f[13]} != 16'h0800 || f[14] != 8'h45 || f[23] != 8'h11) return;
    if (ip != LIP || {f[36], f[37]} != LPORT) return;
    if (ul < 9 || ul - 8 > 2048) return;
    plen = ul - 8;
    if (f.size() < 42 + plen) return;
    acc = 1'b1;
    for (int i = 0; i < (plen + 3) / 4; i++) w.push_back(32'd0);
    for (int i = 0; i < plen; i++) w[i/4] = w[i/4] | ({24'd0, f[42+i]} << (8 * (3 - i % 4)));
  endfunction

  // Drives one frame; s = cycle the first byte was sampled, e = cycle rx_dv=0 is first sampled.
  task automatic send(input logic [7:0] f[$], output int s, output int e);
    s = cyc + 1;
    foreach (f[i]) begin
      rx_dv = 1'b1; rx_data = f[i];
      @(posedge clk); #1;
      if (i == 0) s = cyc;
    end
    rx_dv = 1'b0; rx_data = 8'h00;
    e = cyc + 1;
  endtask

  // Sends a frame and checks the observed burst/pulses against the model.
  task automatic run_frame(input string tag, input logic [7:0] f[$], output int s);
    bit acc; int plen, e;
    logic [31:0] ew[$];
    int b_got, b_rise, b_run, b_ok, b_drop, b_len;
    b_got = got.size(); b_rise = rise_q.size(); b_run = run_q.size();
    b_ok = n_ok; b_drop = n_drop; b_len = oklen_q.size();
    model(f, acc, plen, ew);
    send(f, s, e);
    repeat (ew.size() + 8) @(posedge clk);
    #1;
    chk({tag, "_drops"}, n_drop - b_drop, acc ? 0 : 1);
    chk({tag, "_oks"}, n_ok - b_ok, acc ? 1 : 0);
    chk({tag, "_nwords"}, got.size() - b_got, ew.size());
    for (int k = 0; k < ew.size() && b_got + k < got.size(); k++)
      chk($sformatf("%s_word%0d", tag, k), got[b_got+k], ew[k]);
    if (acc) begin
      chk({tag, "_bursts"}, rise_q.size() - b_rise, 1);
      if (rise_q.size() > b_rise) chk({tag, "_rise_cyc"}, rise_q[b_rise], e + 2);
      if (run_q.size() > b_run) chk({tag, "_run_len"}, run_q[b_run], ew.size());
      if (oklen_q.size() > b_len) chk({tag, "_ok_len"}, oklen_q[b_len], plen);
      chk({tag, "_frame_len"}, frame_len, plen);
    end
    chk({tag, "_zero_idle"}, zero_err, 0);
  endtask

  initial begin
    logic [7:0] f[$], g[$];
    int s, e, b_got, b_ok, b_drop, mode, npay, ulen;
    logic [47:0] mac;
    logic [15:0] port;

    #2 nRST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_en_out", en_out, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_pkt_ok", pkt_ok, 0);
    chk("rst_pkt_drop", pkt_drop, 0);
    nRST = 1'b1;
    @(posedge clk); #1;

    // Two full words 01..08
    build(LMAC, LPORT, 16, 8, 0, f);
    for (int i = 0; i < 8; i++) f[42+i] = 8'(i + 1);
    run_frame("t1", f, s);
    chk("t1_word0_const", got[got.size()-2], 32'h01020304);
    chk("t1_word1_const", got[got.size()-1], 32'h05060708);

    // Partial final word is zero-filled
    build(LMAC, LPORT, 13, 5, 0, f);
    f[42] = 8'hAA; f[43] = 8'hBB; f[44] = 8'hCC; f[45] = 8'hDD; f[46] = 8'hEE;
    run_frame("t2", f, s);
    chk("t2_word1_const", got[got.size()-1], 32'hEE000000);

    // Wrong port: drop pulse right after byte 37
    build(LMAC, 16'h1F91, 16, 8, 0, f);
    run_frame("t3", f, s);
    if (drop_q.size() > 0) chk("t3_drop_cyc", drop_q[drop_q.size()-1], s + 37);

    // udp_len says 100 payload bytes, only 50 sent
    build(LMAC, LPORT, 108, 50, 0, f);
    run_frame("t4", f, s);

    // Broadcast, 4-byte payload padded to 60 bytes
    build(48'hFFFFFFFFFFFF, LPORT, 12, 4, 60, f);
    f[42] = 8'hDE; f[43] = 8'hAD; f[44] = 8'hBE; f[45] = 8'hEF;
    run_frame("t5", f, s);
    chk("t5_word_const", got[got.size()-1], 32'hDEADBEEF);

    // Boundaries: 1-byte payload, udp_len 8, 41- and 1-byte windows
    build(LMAC, LPORT, 9, 1, 0, f);
    run_frame("b_l1", f, s);
    build(LMAC, LPORT, 8, 0, 0, f);
    run_frame("b_ulen8", f, s);
    build(LMAC, LPORT, 16, 8, 0, f);
    f = f[0:40];
    run_frame("b_win41", f, s);
    f = f[0:0];
    run_frame("b_win1", f, s);

    // Reset during word 1 of a 3-word burst
    build(LMAC, LPORT, 20, 12, 0, f);
    b_got = got.size();
    send(f, s, e);
    for (int i = 0; i < 40 && got.size() - b_got < 2; i++) @(negedge clk);
    chk("t6_reached_word1", got.size() - b_got, 2);
    #2 nRST = 1'b0;
    #1;
    chk("t6_en_after_rst", en_out, 0);
    chk("t6_data_after_rst", data_out, 0);
    @(posedge clk); #1;
    nRST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    build(LMAC, LPORT, 20, 12, 0, f);
    run_frame("t6_next", f, s);

    // Frame arriving during a long burst is swallowed without a drop pulse
    build(LMAC, LPORT, 208, 200, 0, f);
    build(LMAC, LPORT, 20, 12, 60, g);
    b_got = got.size(); b_ok = n_ok; b_drop = n_drop;
    send(f, s, e);
    @(posedge clk); #1;
    send(g, s, e);
    repeat (20) @(posedge clk);
    #1;
    chk("ovl_words", got.size() - b_got, 50);
    chk("ovl_oks", n_ok - b_ok, 1);
    chk("ovl_drops", n_drop - b_drop, 0);
    if (got.size() - b_got == 50)
      chk("ovl_last_word", got[b_got+49], {f[238], f[239], f[240], f[241]});

    // Randomized frames against the reference model
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 9);
      mac  = (mode == 1) ? 48'hFFFFFFFFFFFF : LMAC;
      port = LPORT;
      npay = $urandom_range(1, 60);
      ulen = npay + 8;
      if (mode == 2) ulen = $urandom_range(0, 8);
      if (mode == 3) port = 16'($urandom);
      build(mac, port, ulen, npay, (mode == 4) ? $urandom_range(60, 110) : 0, f);
      if (mode == 5) f[$urandom_range(0, 41)] ^= 8'($urandom_range(1, 255));
      if (mode == 6) f = f[0:$urandom_range(0, f.size() - 2)];
      run_frame($sformatf("rnd%0d", r), f, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
